// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS single-cycle main decoder: opcodes, funct codes,
// ALU function codes, datapath select enums and the packed control word.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned ALUFN_W = 4;
    localparam int unsigned SEL_W   = 2;

    // Primary opcodes (instr[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    // R-type funct codes (instr[5:0])
    localparam logic [FUNC_W-1:0] FN_SLL  = 6'b000000;
    localparam logic [FUNC_W-1:0] FN_SRL  = 6'b000010;
    localparam logic [FUNC_W-1:0] FN_SRA  = 6'b000011;
    localparam logic [FUNC_W-1:0] FN_SLLV = 6'b000100;
    localparam logic [FUNC_W-1:0] FN_JR   = 6'b001000;
    localparam logic [FUNC_W-1:0] FN_ADD  = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SUB  = 6'b100010;
    localparam logic [FUNC_W-1:0] FN_AND  = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR   = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_XOR  = 6'b100110;
    localparam logic [FUNC_W-1:0] FN_NOR  = 6'b100111;
    localparam logic [FUNC_W-1:0] FN_SLT  = 6'b101010;
    localparam logic [FUNC_W-1:0] FN_SLTU = 6'b101011;

    // ALU function codes
    localparam logic [ALUFN_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALUFN_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALUFN_W-1:0] ALU_SLT  = 4'b0010;
    localparam logic [ALUFN_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [ALUFN_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [ALUFN_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [ALUFN_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [ALUFN_W-1:0] ALU_LUI  = 4'b0111;
    localparam logic [ALUFN_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [ALUFN_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [ALUFN_W-1:0] ALU_SRA  = 4'b1010;
    localparam logic [ALUFN_W-1:0] ALU_NOR  = 4'b1011;

    typedef enum logic [SEL_W-1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pcsel_e;

    typedef enum logic [SEL_W-1:0] {
        WA_RD  = 2'b00,
        WA_RT  = 2'b01,
        WA_R31 = 2'b10
    } wasel_e;

    typedef enum logic [SEL_W-1:0] {
        WD_PC4 = 2'b00,
        WD_ALU = 2'b01,
        WD_MEM = 2'b10
    } wdsel_e;

    typedef enum logic [SEL_W-1:0] {
        A_REG   = 2'b00,
        A_SHAMT = 2'b01,
        A_K16   = 2'b10
    } asel_e;

    // Full decoded control word driven toward the datapath
    typedef struct packed {
        pcsel_e              pcsel;
        wasel_e              wasel;
        logic                sext;
        logic                bsel;
        wdsel_e              wdsel;
        logic [ALUFN_W-1:0]  alufn;
        logic                wr;
        logic                werf;
        asel_e               asel;
    } ctrl_t;

endpackage

// File: rtl/controller_alu_decode.sv
// R-type funct decoder: func -> ALU function, A-source select, validity and JR flag.
// Shift funcs (SLL/SRL/SRA/SLLV) decode only when CONTROLLER_SHIFT_EN is defined.
module controller_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [FUNC_W-1:0]  func,
    output logic [ALUFN_W-1:0] alufn,
    output asel_e              asel,
    output logic               valid,
    output logic               is_jr
);

    // Funct lookup; anything unlisted reports invalid with zeroed fields
    always_comb begin
        alufn = ALU_ADD;
        asel  = A_REG;
        valid = 1'b0;
        is_jr = 1'b0;
        case (func)
            FN_ADD:  begin alufn = ALU_ADD;  valid = 1'b1; end
            FN_SUB:  begin alufn = ALU_SUB;  valid = 1'b1; end
            FN_AND:  begin alufn = ALU_AND;  valid = 1'b1; end
            FN_OR:   begin alufn = ALU_OR;   valid = 1'b1; end
            FN_XOR:  begin alufn = ALU_XOR;  valid = 1'b1; end
            FN_NOR:  begin alufn = ALU_NOR;  valid = 1'b1; end
            FN_SLT:  begin alufn = ALU_SLT;  valid = 1'b1; end
            FN_SLTU: begin alufn = ALU_SLTU; valid = 1'b1; end
            FN_JR:   begin is_jr = 1'b1;     valid = 1'b1; end
`ifdef CONTROLLER_SHIFT_EN
            FN_SLL:  begin alufn = ALU_SLL; asel = A_SHAMT; valid = 1'b1; end
            FN_SRL:  begin alufn = ALU_SRL; asel = A_SHAMT; valid = 1'b1; end
            FN_SRA:  begin alufn = ALU_SRA; asel = A_SHAMT; valid = 1'b1; end
            FN_SLLV: begin alufn = ALU_SLL; asel = A_REG;   valid = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/controller.sv
// Main decoder for the single-cycle MIPS datapath. Decode outputs are combinational;
// the only state is the sticky illegal-instruction flag.
// Optional feature: define CONTROLLER_SHIFT_EN to decode SLL/SRL/SRA/SLLV.
module controller
    import mips_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNC_W-1:0]  func,
    input  logic               Z,
    output logic [SEL_W-1:0]   pcsel,
    output logic [SEL_W-1:0]   wasel,
    output logic               sext,
    output logic               bsel,
    output logic [SEL_W-1:0]   wdsel,
    output logic [ALUFN_W-1:0] alufn,
    output logic               wr,
    output logic               werf,
    output logic [SEL_W-1:0]   asel,
    output logic               illegal
);

    logic [ALUFN_W-1:0] r_alufn;
    asel_e              r_asel;
    logic               r_valid;
    logic               r_is_jr;

    ctrl_t dec_c;
    ctrl_t out_c;
    logic  illegal_det_c;

    controller_alu_decode u_alu_decode (
        .func  (func),
        .alufn (r_alufn),
        .asel  (r_asel),
        .valid (r_valid),
        .is_jr (r_is_jr)
    );

    // Opcode decode; func-derived fields are consulted only for R-type
    always_comb begin
        dec_c         = '0;
        illegal_det_c = 1'b0;
        case (op)
            OP_LW: begin
                dec_c.wasel = WA_RT;  dec_c.sext = 1'b1; dec_c.bsel = 1'b1;
                dec_c.wdsel = WD_MEM; dec_c.alufn = ALU_ADD; dec_c.werf = 1'b1;
            end
            OP_SW: begin
                dec_c.sext  = 1'b1; dec_c.bsel = 1'b1;
                dec_c.alufn = ALU_ADD; dec_c.wr = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                dec_c.wasel = WA_RT;  dec_c.sext = 1'b1; dec_c.bsel = 1'b1;
                dec_c.wdsel = WD_ALU; dec_c.werf = 1'b1;
                case (op)
                    OP_SLTI:  dec_c.alufn = ALU_SLT;
                    OP_SLTIU: dec_c.alufn = ALU_SLTU;
                    default:  dec_c.alufn = ALU_ADD;
                endcase
            end
            OP_ORI: begin
                dec_c.wasel = WA_RT;  dec_c.bsel = 1'b1;
                dec_c.wdsel = WD_ALU; dec_c.alufn = ALU_OR; dec_c.werf = 1'b1;
            end
            OP_LUI: begin
                dec_c.wasel = WA_RT;  dec_c.bsel = 1'b1;
                dec_c.wdsel = WD_ALU; dec_c.alufn = ALU_LUI; dec_c.werf = 1'b1;
                dec_c.asel  = A_K16;
            end
            OP_BEQ, OP_BNE: begin
                dec_c.sext  = 1'b1;
                dec_c.alufn = ALU_SUB;
                // Branch taken when equality outcome matches the opcode's sense
                dec_c.pcsel = ((op == OP_BEQ) == Z) ? PC_BRANCH : PC_PLUS4;
            end
            OP_J: begin
                dec_c.pcsel = PC_JUMP;
            end
            OP_JAL: begin
                dec_c.pcsel = PC_JUMP; dec_c.wasel = WA_R31;
                dec_c.wdsel = WD_PC4;  dec_c.werf  = 1'b1;
            end
            OP_RTYPE: begin
                if (r_valid) begin
                    dec_c.wdsel = WD_ALU;
                    if (r_is_jr) begin
                        dec_c.pcsel = PC_REG;
                    end else begin
                        dec_c.alufn = r_alufn;
                        dec_c.asel  = r_asel;
                        dec_c.werf  = 1'b1;
                    end
                end else begin
                    illegal_det_c = 1'b1;
                end
            end
            default: begin
                illegal_det_c = 1'b1;
            end
        endcase
    end

    // Reset blanks everything immediately; disable only blocks the write strobes
    always_comb begin
        out_c = dec_c;
        if (!rst_n) begin
            out_c = '0;
        end else if (!enable) begin
            out_c.wr   = 1'b0;
            out_c.werf = 1'b0;
        end
    end

    assign pcsel = out_c.pcsel;
    assign wasel = out_c.wasel;
    assign sext  = out_c.sext;
    assign bsel  = out_c.bsel;
    assign wdsel = out_c.wdsel;
    assign alufn = out_c.alufn;
    assign wr    = out_c.wr;
    assign werf  = out_c.werf;
    assign asel  = out_c.asel;

    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (enable && illegal_det_c) begin
            illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: expected control words are pushed to a
// scoreboard when stimulus is driven and popped when the outputs are sampled.
module tb_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [5:0] op;
    logic [5:0] func;
    logic       Z;
    logic [1:0] pcsel;
    logic [1:0] wasel;
    logic       sext;
    logic       bsel;
    logic [1:0] wdsel;
    logic [3:0] alufn;
    logic       wr;
    logic       werf;
    logic [1:0] asel;
    logic       illegal;

    typedef struct {
        string       tag;
        logic [15:0] vec;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    logic exp_ill;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .op      (op),
        .func    (func),
        .Z       (Z),
        .pcsel   (pcsel),
        .wasel   (wasel),
        .sext    (sext),
        .bsel    (bsel),
        .wdsel   (wdsel),
        .alufn   (alufn),
        .wr      (wr),
        .werf    (werf),
        .asel    (asel),
        .illegal (illegal)
    );

    always #5 clk = ~clk;

    // Packs one table row in the order pcsel wasel sext bsel wdsel alufn wr werf asel
    function automatic logic [15:0] row(input logic [1:0] p, input logic [1:0] wa,
                                        input logic s, input logic b, input logic [1:0] wd,
                                        input logic [3:0] fn, input logic w, input logic rf,
                                        input logic [1:0] a);
        return {p, wa, s, b, wd, fn, w, rf, a};
    endfunction

    // Reference decode table: returns {unsupported, control word} before gating
    function automatic logic [16:0] model(input logic [5:0] o, input logic [5:0] f,
                                          input logic z);
        logic [15:0] v;
        logic        bad;
        v   = 16'h0000;
        bad = 1'b0;
        case (o)
            6'b100011: v = row(2'b00, 2'b01, 1, 1, 2'b10, 4'b0000, 0, 1, 2'b00);
            6'b101011: v = row(2'b00, 2'b00, 1, 1, 2'b00, 4'b0000, 1, 0, 2'b00);
            6'b001000,
            6'b001001: v = row(2'b00, 2'b01, 1, 1, 2'b01, 4'b0000, 0, 1, 2'b00);
            6'b001010: v = row(2'b00, 2'b01, 1, 1, 2'b01, 4'b0010, 0, 1, 2'b00);
            6'b001011: v = row(2'b00, 2'b01, 1, 1, 2'b01, 4'b0011, 0, 1, 2'b00);
            6'b001101: v = row(2'b00, 2'b01, 0, 1, 2'b01, 4'b0101, 0, 1, 2'b00);
            6'b001111: v = row(2'b00, 2'b01, 0, 1, 2'b01, 4'b0111, 0, 1, 2'b10);
            6'b000100: v = row(z ? 2'b01 : 2'b00, 2'b00, 1, 0, 2'b00, 4'b0001, 0, 0, 2'b00);
            6'b000101: v = row(z ? 2'b00 : 2'b01, 2'b00, 1, 0, 2'b00, 4'b0001, 0, 0, 2'b00);
            6'b000010: v = row(2'b10, 2'b00, 0, 0, 2'b00, 4'b0000, 0, 0, 2'b00);
            6'b000011: v = row(2'b10, 2'b10, 0, 0, 2'b00, 4'b0000, 0, 1, 2'b00);
            6'b000000: begin
                case (f)
                    6'b100000: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b0000, 0, 1, 2'b00);
                    6'b100010: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b0001, 0, 1, 2'b00);
                    6'b100100: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b0100, 0, 1, 2'b00);
                    6'b100101: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b0101, 0, 1, 2'b00);
                    6'b100110: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b0110, 0, 1, 2'b00);
                    6'b100111: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b1011, 0, 1, 2'b00);
                    6'b101010: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b0010, 0, 1, 2'b00);
                    6'b101011: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b0011, 0, 1, 2'b00);
                    6'b001000: v = row(2'b11, 2'b00, 0, 0, 2'b01, 4'b0000, 0, 0, 2'b00);
`ifdef CONTROLLER_SHIFT_EN
                    6'b000000: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b1000, 0, 1, 2'b01);
                    6'b000010: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b1001, 0, 1, 2'b01);
                    6'b000011: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b1010, 0, 1, 2'b01);
                    6'b000100: v = row(2'b00, 2'b00, 0, 0, 2'b01, 4'b1000, 0, 1, 2'b00);
`endif
                    default:   bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        return {bad, v};
    endfunction

    // Pops the oldest expectation and compares it against the sampled outputs
    task automatic check_outputs();
        exp_t        e;
        logic [15:0] obs;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL scoreboard_empty observed 0 entries expected 1");
            return;
        end
        e   = sb.pop_front();
        obs = {pcsel, wasel, sext, bsel, wdsel, alufn, wr, werf, asel};
        n_cmp++;
        assert (obs === e.vec) else begin
            n_bad++;
            $error("FAIL %s ctrl observed %b expected %b", e.tag, obs, e.vec);
        end
        n_cmp++;
        assert (illegal === e.ill) else begin
            n_bad++;
            $error("FAIL %s illegal observed %b expected %b", e.tag, illegal, e.ill);
        end
    endtask

    // Drives one instruction, checks decode before the edge, then clocks it
    task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic en);
        logic [16:0] m;
        exp_t        e;
        @(negedge clk);
        op     = o;
        func   = f;
        Z      = z;
        enable = en;
        m      = model(o, f, z);
        e.tag  = tag;
        e.vec  = m[15:0];
        if (!rst_n) begin
            e.vec = 16'h0000;
        end else if (!en) begin
            e.vec[3] = 1'b0;
            e.vec[2] = 1'b0;
        end
        e.ill = exp_ill;
        sb.push_back(e);
        #2;
        check_outputs();
        @(posedge clk);
        if (rst_n && en && m[16]) exp_ill = 1'b1;
        #1;
    endtask

    // Asynchronous reset pulse away from the clock edge
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        exp_ill = 1'b0;
    endtask

    logic [5:0] t_op   [0:22];
    logic [5:0] t_func [0:22];

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        op      = 6'b101011;
        func    = 6'b000000;
        Z       = 1'b0;
        exp_ill = 1'b0;

        // Reset blanks outputs even with SW presented
        step("reset_sw", 6'b101011, 6'b000000, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step("sw_after_reset", 6'b101011, 6'b000000, 1'b0, 1'b1);

        // Every supported row with enable high
        t_op = '{6'b100011, 6'b101011, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                 6'b001101, 6'b001111, 6'b000010, 6'b000011, 6'b000000, 6'b000000,
                 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                 6'b000000, 6'b000100, 6'b000100, 6'b000101, 6'b000101};
        t_func = '{6'b111111, 6'b010101, 6'b000000, 6'b101010, 6'b000000, 6'b000000,
                   6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b100000, 6'b100010,
                   6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                   6'b001000, 6'b000000, 6'b000000, 6'b000000, 6'b000000};
        for (int i = 0; i < 19; i++) begin
            step($sformatf("row%0d_op%b_fn%b", i, t_op[i], t_func[i]),
                 t_op[i], t_func[i], 1'b0, 1'b1);
        end

        // Branch resolution on Z
        step("beq_z0", t_op[19], t_func[19], 1'b0, 1'b1);
        step("beq_z1", t_op[20], t_func[20], 1'b1, 1'b1);
        step("bne_z0", t_op[21], t_func[21], 1'b0, 1'b1);
        step("bne_z1", t_op[22], t_func[22], 1'b1, 1'b1);

        // Unknown func on non-R-type must not disturb decode
        step("lw_func_x", 6'b100011, 6'bxxxxxx, 1'b0, 1'b1);
        step("lui_func_x", 6'b001111, 6'bxxxxxx, 1'b1, 1'b1);

        // Enable gating of write strobes
        step("add_en1", 6'b000000, 6'b100000, 1'b0, 1'b1);
        step("add_en0", 6'b000000, 6'b100000, 1'b0, 1'b0);
        step("sw_en1", 6'b101011, 6'b000000, 1'b0, 1'b1);
        step("sw_en0", 6'b101011, 6'b000000, 1'b0, 1'b0);

        // Unsupported opcode while disabled leaves the flag clear
        step("bad_op_en0", 6'b111111, 6'b000000, 1'b0, 1'b0);
        step("after_bad_en0", 6'b100011, 6'b000000, 1'b0, 1'b1);

        // Unsupported opcode sets the sticky flag, which holds until reset
        step("bad_op_en1", 6'b111111, 6'b000000, 1'b0, 1'b1);
        step("sticky_1", 6'b100011, 6'b000000, 1'b0, 1'b1);
        step("sticky_2", 6'b000000, 6'b100000, 1'b0, 1'b0);
        pulse_reset();
        step("cleared_by_reset", 6'b101011, 6'b000000, 1'b0, 1'b1);

        // Unsupported R-type func
        step("bad_func", 6'b000000, 6'b111111, 1'b0, 1'b1);
        step("bad_func_sticky", 6'b001101, 6'b000000, 1'b0, 1'b1);
        pulse_reset();

        // Shift group: decoded or unsupported depending on the build
        step("sll", 6'b000000, 6'b000000, 1'b0, 1'b1);
        step("srl", 6'b000000, 6'b000010, 1'b0, 1'b1);
        step("sra", 6'b000000, 6'b000011, 1'b0, 1'b1);
        step("sllv", 6'b000000, 6'b000100, 1'b0, 1'b1);
        step("post_shift", 6'b000011, 6'b000000, 1'b0, 1'b1);

        n_cmp++;
        assert (sb.size() == 0) else begin
            n_bad++;
            $error("FAIL scoreboard_drain observed %0d entries expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
